// File: rtl/link_pkg.sv
// Shared constants and types for the 4-slot bit-serial register link.
package link_pkg;

  localparam int LINK_SLOTS  = 4;
  localparam int LINK_WORD_W = 32;
  localparam int LINK_EDGES  = 133;
  localparam int LINK_BUS_W  = LINK_SLOTS * LINK_WORD_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC_LO,
    ST_SYNC_HI,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_FINISH
  } link_state_e;

  typedef logic [LINK_WORD_W-1:0] link_word_t;

  // During slot k the master sends the word that the next sync commits, i.e. (k+1) mod 4.
  function automatic logic [1:0] tx_word_sel(input logic [2:0] slot);
    return slot[1:0] + 2'd1;
  endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer for asynchronous inputs into the clk_sys domain.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk_sys,
  input  logic             sys_reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_sys) begin
    if (sys_reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      // NOTE: non-blocking keeps two real stages; a blocking chain collapses to one flop.
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/serial_link_master.sv
// Master end of the 4-slot serial register link: generates clk_data/data_sync_en,
// shifts tx words out LSB first and collects the slave's output slots.
module serial_link_master
  import link_pkg::*;
#(
  parameter int HALF_DIV = 4
) (
  input  logic                  clk_sys,
  input  logic                  sys_reset,
  input  logic                  start,
  input  logic [LINK_BUS_W-1:0] tx_words,
  output logic [LINK_BUS_W-1:0] rx_words,
  output logic                  busy,
  output logic                  done,
  output logic                  clk_data,
  output logic                  data_sync_en,
  output logic                  datainbit,
  input  logic                  dataoutbit
);

  localparam logic [7:0] HALF_LAST = 8'(HALF_DIV - 1);

  link_state_e state_q;
  logic [7:0]  half_cnt_q;
  logic [4:0]  bit_idx_q;
  logic [2:0]  slot_q;

  logic [LINK_SLOTS-1:0][LINK_WORD_W-1:0] tx_shadow_q;
  logic [LINK_SLOTS-1:0][LINK_WORD_W-1:0] rx_words_q;
  link_word_t                             rx_shift_q;

  logic busy_q, done_q, clk_data_q, sync_en_q, datain_q;

  logic       dout_sync;
  logic       half_last;
  logic [4:0] bit_idx_d;
  logic       tx_bit_d;

  sync2 #(.WIDTH(1)) u_dout_sync (
    .clk_sys   (clk_sys),
    .sys_reset (sys_reset),
    .d_i       (dataoutbit),
    .q_o       (dout_sync)
  );

  assign half_last = (half_cnt_q == HALF_LAST);
  // Bit to present on the next SHIFT_LO entry: bit 0 after a sync, else the following bit.
  assign bit_idx_d = (state_q == ST_SHIFT_HI) ? bit_idx_q + 5'd1 : 5'd0;
  assign tx_bit_d  = tx_shadow_q[tx_word_sel(slot_q)][bit_idx_d];

  always_ff @(posedge clk_sys) begin
    if (sys_reset) begin
      state_q     <= ST_IDLE;
      half_cnt_q  <= '0;
      bit_idx_q   <= '0;
      slot_q      <= '0;
      tx_shadow_q <= '0;
      // NOTE: rx_words_q is plain flops, not a RAM, so it is cleared with the control state.
      rx_words_q  <= '0;
      rx_shift_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      clk_data_q  <= 1'b0;
      sync_en_q   <= 1'b0;
      datain_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (state_q inside {ST_SYNC_LO, ST_SYNC_HI, ST_SHIFT_LO, ST_SHIFT_HI}) begin
        half_cnt_q <= half_last ? 8'd0 : half_cnt_q + 8'd1;
      end

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            tx_shadow_q <= tx_words;
            state_q     <= ST_SYNC_LO;
            busy_q      <= 1'b1;
            clk_data_q  <= 1'b0;
            sync_en_q   <= 1'b1;
            datain_q    <= 1'b0;
            half_cnt_q  <= '0;
            bit_idx_q   <= '0;
            slot_q      <= '0;
          end
        end

        ST_SYNC_LO: begin
          if (half_last) begin
            state_q    <= ST_SYNC_HI;
            clk_data_q <= 1'b1;
          end
        end

        ST_SYNC_HI: begin
          if (half_last) begin
            clk_data_q <= 1'b0;
            sync_en_q  <= 1'b0;
            if (slot_q == 3'd4) begin
              state_q  <= ST_FINISH;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              datain_q <= 1'b0;
              slot_q   <= '0;
            end else begin
              state_q   <= ST_SHIFT_LO;
              bit_idx_q <= bit_idx_d;
              datain_q  <= tx_bit_d;
            end
          end
        end

        ST_SHIFT_LO: begin
          if (half_last) begin
            state_q    <= ST_SHIFT_HI;
            clk_data_q <= 1'b1;
            rx_shift_q <= {dout_sync, rx_shift_q[LINK_WORD_W-1:1]};
          end
        end

        ST_SHIFT_HI: begin
          if (half_last) begin
            clk_data_q <= 1'b0;
            if (bit_idx_q == 5'd31) begin
              rx_words_q[slot_q[1:0]] <= rx_shift_q;
              state_q   <= ST_SYNC_LO;
              slot_q    <= slot_q + 3'd1;
              bit_idx_q <= '0;
              sync_en_q <= 1'b1;
              datain_q  <= 1'b0;
            end else begin
              state_q   <= ST_SHIFT_LO;
              bit_idx_q <= bit_idx_d;
              datain_q  <= tx_bit_d;
            end
          end
        end

        ST_FINISH: state_q <= ST_IDLE;

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rx_words     = rx_words_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign clk_data     = clk_data_q;
  assign data_sync_en = sync_en_q;
  assign datainbit    = datain_q;

endmodule

// File: tb/tb_serial_link_master.sv
// Bench for serial_link_master against a behavioural model of the slave shifter in top.
module tb_serial_link_master;
  import link_pkg::*;

  localparam int H       = 2;
  localparam int TXN_CYC = 1 + 266 * H;
  localparam int B2B_CYC = TXN_CYC + 1;

  logic                  clk_sys = 1'b0;
  logic                  sys_reset = 1'b0;
  logic                  start = 1'b0;
  logic [LINK_BUS_W-1:0] tx_words = '0;
  logic [LINK_BUS_W-1:0] rx_words;
  logic                  busy, done, clk_data, data_sync_en, datainbit, dataoutbit;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;

  serial_link_master #(.HALF_DIV(H)) dut (
    .clk_sys      (clk_sys),
    .sys_reset    (sys_reset),
    .start        (start),
    .tx_words     (tx_words),
    .rx_words     (rx_words),
    .busy         (busy),
    .done         (done),
    .clk_data     (clk_data),
    .data_sync_en (data_sync_en),
    .datainbit    (datainbit),
    .dataoutbit   (dataoutbit)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    cyc <= cyc + 1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  // Behavioural slave: commit/load on sync rises, shift MSB-in on plain rises.
  logic [31:0] s_in  [4];
  logic [31:0] s_out [4];
  logic [31:0] s_sr;
  logic [1:0]  s_state;
  logic [4:0]  s_cnt;
  int          sync_rises = 0;
  int          shift_rises = 0;

  always @(posedge clk_data or posedge sys_reset) begin
    if (sys_reset) begin
      s_sr    <= '0;
      s_state <= '0;
      s_cnt   <= '0;
      for (int i = 0; i < 4; i++) s_in[i] <= '0;
    end else if (data_sync_en) begin
      s_in[s_state] <= s_sr;
      s_sr          <= s_out[s_state];
      sync_rises    <= sync_rises + 1;
    end else begin
      s_sr        <= {datainbit, s_sr[31:1]};
      s_cnt       <= s_cnt + 5'd1;
      if (s_cnt == 5'd31) s_state <= s_state + 2'd1;
      shift_rises <= shift_rises + 1;
    end
  end

  assign dataoutbit = s_sr[0];

  typedef struct packed {
    logic [LINK_BUS_W-1:0] rx;
    logic [LINK_BUS_W-1:0] sin;
  } exp_t;

  exp_t sb_q[$];

  task automatic set_slave_out(input logic [LINK_BUS_W-1:0] v);
    for (int i = 0; i < 4; i++) s_out[i] = v[32*i +: 32];
  endtask

  function automatic logic [LINK_BUS_W-1:0] slave_in_flat();
    return {s_in[3], s_in[2], s_in[1], s_in[0]};
  endfunction

  task automatic push_exp(input logic [LINK_BUS_W-1:0] tx, input logic [LINK_BUS_W-1:0] sout);
    exp_t e;
    e.rx  = sout;
    e.sin = tx;
    sb_q.push_back(e);
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk_sys);
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    sys_reset = 1'b1;
    start     = 1'b0;
    set_slave_out('0);
    repeat (3) @(negedge clk_sys);
    checks++; if (rx_words !== '0) begin errors++; $display("FAIL reset rx_words: got %h want 0", rx_words); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", done); end
    checks++; if (clk_data !== 1'b0) begin errors++; $display("FAIL reset clk_data: got %b want 0", clk_data); end
    checks++; if (data_sync_en !== 1'b0) begin errors++; $display("FAIL reset data_sync_en: got %b want 0", data_sync_en); end
    checks++; if (datainbit !== 1'b0) begin errors++; $display("FAIL reset datainbit: got %b want 0", datainbit); end
    sys_reset = 1'b0;
    repeat (8) @(negedge clk_sys);
    checks++; if (busy !== 1'b0 || clk_data !== 1'b0) begin
      errors++; $display("FAIL idle_no_start busy/clk_data: got %b/%b want 0/0", busy, clk_data);
    end
  endtask

  task automatic test_loopback();
    logic [LINK_BUS_W-1:0] tx   = {32'h00000001, 32'hDEADBEEF, 32'h22222222, 32'h11111111};
    logic [LINK_BUS_W-1:0] sout = {32'hCAFEF00D, 32'h80000000, 32'h0F0F0F0F, 32'hA5A5A5A5};
    int  t0, s0, sh0;
    bit  seen;
    exp_t e;
    tx_words = tx;
    set_slave_out(sout);
    push_exp(tx, sout);
    s0  = sync_rises;
    sh0 = shift_rises;
    t0  = cyc;
    start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    checks++; if (busy !== 1'b1 || clk_data !== 1'b0 || data_sync_en !== 1'b1) begin
      errors++; $display("FAIL first_cycle busy/clk_data/sync: got %b/%b/%b want 1/0/1", busy, clk_data, data_sync_en);
    end
    repeat (H - 1) @(negedge clk_sys);
    checks++; if (clk_data !== 1'b0) begin errors++; $display("FAIL pre_rise clk_data: got %b want 0", clk_data); end
    @(negedge clk_sys);
    checks++; if (clk_data !== 1'b1) begin errors++; $display("FAIL first_rise clk_data: got %b want 1", clk_data); end
    wait_done(TXN_CYC + 20, seen);
    checks++; if (!seen) begin errors++; $display("FAIL loopback done: got timeout want pulse"); end
    checks++; if (cyc - t0 !== TXN_CYC) begin errors++; $display("FAIL loopback latency: got %0d want %0d", cyc - t0, TXN_CYC); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_with_done: got %b want 0", busy); end
    e = sb_q.pop_front();
    for (int k = 0; k < 4; k++) begin
      checks++; if (rx_words[32*k +: 32] !== e.rx[32*k +: 32]) begin
        errors++; $display("FAIL loopback rx[%0d]: got %h want %h", k, rx_words[32*k +: 32], e.rx[32*k +: 32]);
      end
      checks++; if (s_in[k] !== e.sin[32*k +: 32]) begin
        errors++; $display("FAIL loopback slave_in[%0d]: got %h want %h", k, s_in[k], e.sin[32*k +: 32]);
      end
    end
    checks++; if (sync_rises - s0 !== 5) begin errors++; $display("FAIL edge_count sync: got %0d want 5", sync_rises - s0); end
    checks++; if (shift_rises - sh0 !== LINK_EDGES - 5) begin
      errors++; $display("FAIL edge_count shift: got %0d want %0d", shift_rises - sh0, LINK_EDGES - 5);
    end
    checks++; if (s_state !== 2'd0 || s_cnt !== 5'd0) begin
      errors++; $display("FAIL slave_realign state/cnt: got %0d/%0d want 0/0", s_state, s_cnt);
    end
    @(negedge clk_sys);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_single_cycle: got %b want 0", done); end
  endtask

  task automatic test_start_while_busy();
    logic [LINK_BUS_W-1:0] tx = {32'h13579BDF, 32'h2468ACE0, 32'hFFFF0000, 32'h0000FFFF};
    logic [LINK_BUS_W-1:0] sout;
    int  dc0;
    bit  seen;
    exp_t e;
    sout = {$urandom, $urandom, $urandom, $urandom};
    tx_words = tx;
    set_slave_out(sout);
    dc0 = done_cnt;
    repeat (10) @(negedge clk_sys);
    push_exp(tx, sout);
    start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    repeat (189) @(negedge clk_sys);
    start    = 1'b1;
    tx_words = ~tx;
    @(negedge clk_sys);
    start = 1'b0;
    wait_done(TXN_CYC, seen);
    checks++; if (!seen) begin errors++; $display("FAIL busy_start done: got timeout want pulse"); end
    e = sb_q.pop_front();
    checks++; if (rx_words !== e.rx) begin errors++; $display("FAIL busy_start rx_words: got %h want %h", rx_words, e.rx); end
    checks++; if (slave_in_flat() !== e.sin) begin
      errors++; $display("FAIL busy_start slave_in: got %h want %h", slave_in_flat(), e.sin);
    end
    repeat (TXN_CYC) @(negedge clk_sys);
    checks++; if (done_cnt - dc0 !== 1) begin errors++; $display("FAIL busy_start done_count: got %0d want 1", done_cnt - dc0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start idle busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [LINK_BUS_W-1:0] tx1   = {32'hAAAA5555, 32'h01234567, 32'h89ABCDEF, 32'h76543210};
    logic [LINK_BUS_W-1:0] sout1 = {32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00};
    logic [LINK_BUS_W-1:0] tx2   = {32'h0BADF00D, 32'hFEEDFACE, 32'h00000000, 32'hFFFFFFFF};
    logic [LINK_BUS_W-1:0] sout2 = {32'h7FFFFFFF, 32'h00000001, 32'hC3C3C3C3, 32'h3C3C3C3C};
    bit   seen;
    exp_t e;
    tx_words = tx1;
    set_slave_out(sout1);
    push_exp(tx1, sout1);
    start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    repeat (299) @(negedge clk_sys);
    sys_reset = 1'b1;
    @(negedge clk_sys);
    sys_reset = 1'b0;
    void'(sb_q.pop_front());
    checks++; if (rx_words !== '0) begin errors++; $display("FAIL mid_reset rx_words: got %h want 0", rx_words); end
    checks++; if (busy !== 1'b0 || clk_data !== 1'b0 || data_sync_en !== 1'b0 || datainbit !== 1'b0) begin
      errors++; $display("FAIL mid_reset outputs busy/clk/sync/din: got %b/%b/%b/%b want 0/0/0/0",
                         busy, clk_data, data_sync_en, datainbit);
    end
    repeat (3) @(negedge clk_sys);
    tx_words = tx2;
    set_slave_out(sout2);
    push_exp(tx2, sout2);
    start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    wait_done(TXN_CYC + 20, seen);
    checks++; if (!seen) begin errors++; $display("FAIL after_reset done: got timeout want pulse"); end
    e = sb_q.pop_front();
    checks++; if (rx_words !== e.rx) begin errors++; $display("FAIL after_reset rx_words: got %h want %h", rx_words, e.rx); end
    checks++; if (slave_in_flat() !== e.sin) begin
      errors++; $display("FAIL after_reset slave_in: got %h want %h", slave_in_flat(), e.sin);
    end
  endtask

  task automatic test_back_to_back();
    logic [LINK_BUS_W-1:0] tx1   = {32'h10203040, 32'h50607080, 32'h90A0B0C0, 32'hD0E0F000};
    logic [LINK_BUS_W-1:0] sout1 = {32'hFACEB00C, 32'h12345678, 32'h87654321, 32'h00FF00FF};
    logic [LINK_BUS_W-1:0] tx2   = {32'h5A5A5A5A, 32'hA5A5A5A5, 32'h0F1E2D3C, 32'h4B5A6978};
    logic [LINK_BUS_W-1:0] sout2 = {32'h80000001, 32'h7E7E7E7E, 32'h00000000, 32'hFFFFFFFF};
    int   t1, t2;
    bit   seen;
    exp_t e;
    tx_words = tx1;
    set_slave_out(sout1);
    push_exp(tx1, sout1);
    push_exp(tx2, sout2);
    start = 1'b1;
    wait_done(TXN_CYC + 20, seen);
    t1 = cyc;
    checks++; if (!seen) begin errors++; $display("FAIL b2b first done: got timeout want pulse"); end
    e = sb_q.pop_front();
    checks++; if (rx_words !== e.rx) begin errors++; $display("FAIL b2b first rx_words: got %h want %h", rx_words, e.rx); end
    checks++; if (slave_in_flat() !== e.sin) begin
      errors++; $display("FAIL b2b first slave_in: got %h want %h", slave_in_flat(), e.sin);
    end
    tx_words = tx2;
    set_slave_out(sout2);
    wait_done(B2B_CYC + 20, seen);
    t2 = cyc;
    start = 1'b0;
    checks++; if (!seen) begin errors++; $display("FAIL b2b second done: got timeout want pulse"); end
    checks++; if (t2 - t1 !== B2B_CYC) begin errors++; $display("FAIL b2b spacing: got %0d want %0d", t2 - t1, B2B_CYC); end
    e = sb_q.pop_front();
    checks++; if (rx_words !== e.rx) begin errors++; $display("FAIL b2b second rx_words: got %h want %h", rx_words, e.rx); end
    checks++; if (slave_in_flat() !== e.sin) begin
      errors++; $display("FAIL b2b second slave_in: got %h want %h", slave_in_flat(), e.sin);
    end
    repeat (5) @(negedge clk_sys);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b end busy: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
